// File: rtl/rd_ctrl_pf.sv
// Read-domain controller for the async FIFO: wptr synchroniser, fill level, flags,
// and an optional first-word-fall-through mode backed by a 2-entry prefetch buffer.
module rd_ctrl_pf #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  input  logic                  rinc_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  rempty_o,
  output logic                  raempty_o,
  output logic [ADDR_WIDTH:0]   rlevel_o,
  output logic                  runderflow_o,
  input  logic                  runderflow_clr_i,
  output logic [ADDR_WIDTH:0]   rptr_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  output logic                  ram_ren_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0]         wsync_q [SYNC_STAGES];
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  underflow_q, underflow_d;
  logic                  std_valid_q, std_valid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] pf_q [2];
  logic [DATA_WIDTH-1:0] pf_d [2];
  logic [1:0]            pf_cnt_q, pf_cnt_d;
  logic                  inflight_q, inflight_d;

  logic [PW-1:0]         wq_bin, mem_cnt, level;
  logic                  mem_empty, ren, pop, rvalid, rempty;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
    end else begin
      wsync_q[0] <= wptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
    end
  end

  always_comb begin
    wq_bin      = gray2bin(wsync_q[SYNC_STAGES-1]);
    mem_cnt     = wq_bin - rbin_q;
    mem_empty   = (mem_cnt == '0);
    pop         = 1'b0;
    occ         = 2'd0;
    ren         = 1'b0;
    rvalid      = 1'b0;
    rempty      = 1'b1;
    rdata       = hold_q;
    level       = mem_cnt;
    pf_d        = pf_q;
    pf_cnt_d    = pf_cnt_q;
    inflight_d  = 1'b0;
    std_valid_d = 1'b0;
    hold_d      = hold_q;
    if (FWFT != 0) begin
      rvalid = (pf_cnt_q != 2'd0);
      pop    = rinc_i & rvalid;
      occ    = pf_cnt_q + {1'b0, inflight_q};
      ren    = ~mem_empty & ((occ - {1'b0, pop}) < 2'd2);
      rdata  = pf_q[0];
      rempty = ~rvalid;
      level  = mem_cnt + PW'(pf_cnt_q) + PW'(inflight_q);
      // Pop shifts the head out first, so a returning word always lands at the new tail
      if (pop) begin
        pf_d[0]  = pf_q[1];
        pf_cnt_d = pf_cnt_q - 2'd1;
      end
      if (inflight_q) begin
        pf_d[pf_cnt_d[0]] = ram_rdata_i;
        pf_cnt_d          = pf_cnt_d + 2'd1;
      end
      inflight_d = ren;
    end else begin
      ren         = rinc_i & ~mem_empty;
      rvalid      = std_valid_q;
      rdata       = std_valid_q ? ram_rdata_i : hold_q;
      rempty      = mem_empty;
      std_valid_d = ren;
      if (std_valid_q) hold_d = ram_rdata_i;
    end
    rbin_d      = rbin_q + PW'(ren);
    rptr_d      = rbin_d ^ (rbin_d >> 1);
    underflow_d = (rinc_i & rempty) | (underflow_q & ~runderflow_clr_i);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      underflow_q <= 1'b0;
      std_valid_q <= 1'b0;
      hold_q      <= '0;
      pf_q[0]     <= '0;
      pf_q[1]     <= '0;
      pf_cnt_q    <= 2'd0;
      inflight_q  <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      underflow_q <= underflow_d;
      std_valid_q <= std_valid_d;
      hold_q      <= hold_d;
      pf_q        <= pf_d;
      pf_cnt_q    <= pf_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign rdata_o      = rdata;
  assign rvalid_o     = rvalid;
  assign rempty_o     = rempty;
  assign raempty_o    = (level <= THRESH);
  assign rlevel_o     = level;
  assign runderflow_o = underflow_q;
  assign rptr_o       = rptr_q;
  assign ram_raddr_o  = rbin_q[ADDR_WIDTH-1:0];
  assign ram_ren_o    = ren;

endmodule

// File: tb/tb_rd_ctrl_pf.sv
// Directed bench for rd_ctrl_pf: one standard-mode and one FWFT instance, each
// with its own synchronous-read RAM model, checked against hand-computed values.
module tb_rd_ctrl_pf;

  logic        rclk = 1'b0;
  logic        clkEn = 1'b0;
  logic        rrst_n;

  logic [4:0]  sW, fW;
  logic        sInc, sClr, fInc, fClr;
  logic [31:0] sRdata, fRdata, sRamRdata, fRamRdata;
  logic        sRvalid, sRempty, sRaempty, sUfl, sRen;
  logic        fRvalid, fRempty, fRaempty, fUfl, fRen;
  logic [4:0]  sLevel, fLevel, sRptr, fRptr;
  logic [3:0]  sRaddr, fRaddr;
  logic [31:0] sMem [16];
  logic [31:0] fMem [16];

  int          checks = 0;
  int          failures = 0;
  logic [4:0]  baseB, tb5, prevRptr;

  always begin
    #5;
    if (clkEn) rclk = ~rclk;
  end

  rd_ctrl_pf #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SYNC_STAGES(2), .AEMPTY_THRESH(2), .FWFT(0)) uStd (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray_i(sW), .rinc_i(sInc),
    .rdata_o(sRdata), .rvalid_o(sRvalid), .rempty_o(sRempty), .raempty_o(sRaempty),
    .rlevel_o(sLevel), .runderflow_o(sUfl), .runderflow_clr_i(sClr), .rptr_o(sRptr),
    .ram_raddr_o(sRaddr), .ram_ren_o(sRen), .ram_rdata_i(sRamRdata));

  rd_ctrl_pf #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SYNC_STAGES(2), .AEMPTY_THRESH(2), .FWFT(1)) uFwft (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray_i(fW), .rinc_i(fInc),
    .rdata_o(fRdata), .rvalid_o(fRvalid), .rempty_o(fRempty), .raempty_o(fRaempty),
    .rlevel_o(fLevel), .runderflow_o(fUfl), .runderflow_clr_i(fClr), .rptr_o(fRptr),
    .ram_raddr_o(fRaddr), .ram_ren_o(fRen), .ram_rdata_i(fRamRdata));

  always @(posedge rclk) begin
    if (sRen) sRamRdata <= sMem[sRaddr];
    if (fRen) fRamRdata <= fMem[fRaddr];
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic si, input logic sc, input logic fi, input logic fc);
    @(negedge rclk);
    sInc = si; sClr = sc; fInc = fi; fClr = fc;
    #1;
  endtask

  initial begin
    sRamRdata = '0; fRamRdata = '0;
    for (int i = 0; i < 16; i++) begin
      sMem[i] = 32'hA000_0000 + i;
      fMem[i] = 32'hB000_0000 + i;
    end
    rrst_n = 1'b0; sW = '0; fW = '0;
    sInc = 0; sClr = 0; fInc = 0; fClr = 0;
    #20;
    checkOutput("rst_rempty", sRempty, 1);
    checkOutput("rst_raempty", sRaempty, 1);
    checkOutput("rst_rvalid", sRvalid, 0);
    checkOutput("rst_rlevel", sLevel, 0);
    checkOutput("rst_rptr", sRptr, 0);
    checkOutput("rst_ufl", sUfl, 0);
    checkOutput("rst_ren", sRen, 0);
    checkOutput("rst_rdata", sRdata, 0);
    checkOutput("rst_f_rvalid", fRvalid, 0);
    checkOutput("rst_f_rempty", fRempty, 1);
    clkEn = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Standard mode: two words trickle in through the synchroniser
    applyStimulus(0, 0, 0, 0); sW = 5'd1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("std_sync_lat1", sRempty, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("std_sync_lat2", sRempty, 0);
    checkOutput("std_level1", sLevel, 1);
    sW = 5'd3;
    applyStimulus(0, 0, 0, 0);
    checkOutput("std_level1b", sLevel, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("std_level2", sLevel, 2);
    checkOutput("std_aempty2", sRaempty, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("std_a_ren", sRen, 1);
    checkOutput("std_a_raddr", sRaddr, 0);
    checkOutput("std_a_rvalid", sRvalid, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("std_b_ren", sRen, 1);
    checkOutput("std_b_raddr", sRaddr, 1);
    checkOutput("std_b_rvalid", sRvalid, 1);
    checkOutput("std_b_rdata", sRdata, 32'hA000_0000);
    checkOutput("std_b_level", sLevel, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("std_c_ren", sRen, 0);
    checkOutput("std_c_rvalid", sRvalid, 1);
    checkOutput("std_c_rdata", sRdata, 32'hA000_0001);
    checkOutput("std_c_rempty", sRempty, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("std_d_rvalid", sRvalid, 0);
    checkOutput("std_d_hold", sRdata, 32'hA000_0001);
    checkOutput("std_d_ufl", sUfl, 1);
    checkOutput("std_d_rptr", sRptr, 3);

    // Underflow clear and set/clear race
    applyStimulus(0, 1, 0, 0);
    checkOutput("ufl_before_clr", sUfl, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ufl_cleared", sUfl, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ufl_race_pre", sUfl, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("ufl_race_set_wins", sUfl, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ufl_clr_alone", sUfl, 0);
    checkOutput("ufl_rptr_kept", sRptr, 3);

    // FWFT: five words appear at once
    applyStimulus(0, 0, 0, 0); fW = gray(5'd5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fw_e1_rvalid", fRvalid, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fw_e2_ren", fRen, 1);
    checkOutput("fw_e2_level", fLevel, 5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fw_e3_rvalid", fRvalid, 0);
    checkOutput("fw_e3_level", fLevel, 5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fw_e4_rvalid", fRvalid, 1);
    checkOutput("fw_e4_rdata", fRdata, 32'hB000_0000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("fw_pop_rvalid", fRvalid, 1);
      checkOutput("fw_pop_rdata", fRdata, 32'hB000_0000 + k);
      checkOutput("fw_pop_level", fLevel, 5 - k);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("fw_drained_rvalid", fRvalid, 0);
    checkOutput("fw_drained_rempty", fRempty, 1);
    checkOutput("fw_drained_ufl", fUfl, 0);

    // FWFT levels around the almost-empty threshold
    fW = gray(5'd8);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0);
    checkOutput("lvl3_level", fLevel, 3);
    checkOutput("lvl3_aempty", fRaempty, 0);
    checkOutput("lvl3_rdata", fRdata, 32'hB000_0005);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lvl_pop_level", fLevel, 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lvl2_level", fLevel, 2);
    checkOutput("lvl2_aempty", fRaempty, 1);
    checkOutput("lvl2_rdata", fRdata, 32'hB000_0006);

    // Standard mode full depth, two drains, rbin wraps on the second
    baseB = 5'd2;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 16; k++) begin
        tb5 = baseB + 5'(k);
        sMem[tb5[3:0]] = 32'hC000_0000 + (p << 8) + k;
      end
      tb5 = baseB + 5'd16;
      sW = gray(tb5);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
      checkOutput("full_level", sLevel, 16);
      checkOutput("full_aempty", sRaempty, 0);
      prevRptr = sRptr;
      for (int k = 0; k <= 16; k++) begin
        applyStimulus(k < 16, 0, 0, 0);
        tb5 = baseB + 5'(k);
        checkOutput("drain_rptr", sRptr, gray(tb5));
        checkOutput("drain_level", sLevel, 16 - k);
        checkOutput("drain_ren", sRen, k < 16);
        if (k < 16) checkOutput("drain_raddr", sRaddr, tb5[3:0]);
        if (k > 0) begin
          checkOutput("drain_rvalid", sRvalid, 1);
          checkOutput("drain_rdata", sRdata, 32'hC000_0000 + (p << 8) + k - 1);
          checkOutput("drain_rptr_1bit", $countones(sRptr ^ prevRptr), 1);
        end
        prevRptr = sRptr;
      end
      baseB = baseB + 5'd16;
    end
    checkOutput("wrap_rptr", sRptr, gray(5'd2));
    checkOutput("wrap_rempty", sRempty, 1);

    // Reset in mid-operation discards buffered words immediately
    applyStimulus(0, 0, 0, 0);
    checkOutput("mid_pre_rvalid", fRvalid, 1);
    rrst_n = 1'b0;
    #1;
    checkOutput("mid_rst_f_rvalid", fRvalid, 0);
    checkOutput("mid_rst_f_level", fLevel, 0);
    checkOutput("mid_rst_f_rempty", fRempty, 1);
    checkOutput("mid_rst_f_rdata", fRdata, 0);
    checkOutput("mid_rst_s_rptr", sRptr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
